// File: rtl/efc_tck_dr.sv
// efc_tck_dr: JTAG-style shift data register with channel capture/update and length checking
module efc_tck_dr #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int CHW   = 2,
    parameter int CNTW  = 6
) (
    input  logic                 tck,
    input  logic                 arst_l,
    input  logic                 ctu_efc_capturedr,
    input  logic                 ctu_efc_shiftdr,
    input  logic                 ctu_efc_updatedr,
    input  logic                 ctu_efc_data_in,
    input  logic                 ctu_efc_bypass,
    input  logic [CHW-1:0]       ctu_efc_ch_sel,
    input  logic [NCH*WIDTH-1:0] cap_data,
    input  logic                 clr_err,
    output logic                 efc_ctu_data_out,
    output logic [WIDTH-1:0]     upd_data,
    output logic [NCH-1:0]       upd_vld,
    output logic                 len_err
);
    typedef enum logic [1:0] {IDLE, CAPT, SHIFT} state_t;

    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(WIDTH + 1);

    state_t           state, state_d;
    logic [WIDTH-1:0] sr, cap_slice, sr_shifted;
    logic [CNTW-1:0]  cnt;
    logic [CHW-1:0]   ch_q;
    logic             byp_q, byp_bit;
    logic             do_cap, do_shift, do_upd, active, commit, err_set;

    // command priority decode and next-state selection
    always_comb begin
        do_cap   = ctu_efc_capturedr;
        do_shift = !ctu_efc_capturedr && ctu_efc_shiftdr;
        do_upd   = !ctu_efc_capturedr && !ctu_efc_shiftdr && ctu_efc_updatedr;
        active   = state != IDLE;
        state_d  = do_cap             ? CAPT  :
                   do_shift && active ? SHIFT :
                   do_upd && active   ? IDLE  : state;
        commit   = do_upd && active && !byp_q && cnt == CNT_FULL && int'(ch_q) < NCH;
        err_set  = do_upd && active && !byp_q && !(cnt == CNT_FULL && int'(ch_q) < NCH);
        sr_shifted = {sr[WIDTH-2:0], ctu_efc_data_in};
    end

    // select the capture slice; out-of-range channels capture zeros
    always_comb begin
        cap_slice = '0;
        for (int k = 0; k < NCH; k++)
            if (int'(ctu_efc_ch_sel) == k) cap_slice = cap_data[k*WIDTH +: WIDTH];
    end

    // FSM state register
    always_ff @(posedge tck or negedge arst_l)
        if (!arst_l) state <= IDLE;
        else         state <= state_d;

    // shift datapath, commit strobe and sticky length error
    always_ff @(posedge tck or negedge arst_l) begin
        if (!arst_l) begin
            sr       <= '0;
            cnt      <= '0;
            ch_q     <= '0;
            byp_q    <= 1'b0;
            byp_bit  <= 1'b0;
            upd_data <= '0;
            upd_vld  <= '0;
            len_err  <= 1'b0;
        end else begin
            upd_vld <= '0;
            if (do_cap) begin
                sr      <= cap_slice;
                ch_q    <= ctu_efc_ch_sel;
                byp_q   <= ctu_efc_bypass;
                cnt     <= '0;
                byp_bit <= 1'b0;
            end else if (do_shift) begin
                if (!active) sr <= sr_shifted;
                else if (byp_q) byp_bit <= ctu_efc_data_in;
                else begin
                    sr  <= sr_shifted;
                    cnt <= (cnt == CNT_SAT) ? cnt : cnt + CNTW'(1);
                end
            end
            if (commit) begin
                upd_data <= sr;
                upd_vld  <= NCH'(1) << ch_q;
            end
            len_err <= err_set | (len_err & ~clr_err);
        end
    end

    assign efc_ctu_data_out = byp_q ? byp_bit : sr[WIDTH-1];
endmodule

// File: tb/tb_efc_tck_dr.sv
// tb_efc_tck_dr: directed table and sequence checks for efc_tck_dr
module tb_efc_tck_dr;
    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int CHW   = 3;
    localparam int CNTW  = 6;

    logic                 tck = 1'b0;
    logic                 arst_l = 1'b0;
    logic                 cap = 1'b0, sh = 1'b0, upd = 1'b0, din = 1'b0, byp = 1'b0, clr = 1'b0;
    logic [CHW-1:0]       ch_sel = '0;
    logic [NCH*WIDTH-1:0] cap_data;
    logic                 dout;
    logic [WIDTH-1:0]     upd_data;
    logic [NCH-1:0]       upd_vld;
    logic                 len_err;
    int                   checks = 0;
    int                   errors = 0;

    efc_tck_dr #(.WIDTH(WIDTH), .NCH(NCH), .CHW(CHW), .CNTW(CNTW)) dut (
        .tck(tck), .arst_l(arst_l),
        .ctu_efc_capturedr(cap), .ctu_efc_shiftdr(sh), .ctu_efc_updatedr(upd),
        .ctu_efc_data_in(din), .ctu_efc_bypass(byp), .ctu_efc_ch_sel(ch_sel),
        .cap_data(cap_data), .clr_err(clr),
        .efc_ctu_data_out(dout), .upd_data(upd_data), .upd_vld(upd_vld), .len_err(len_err)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic           c, s, u, d, b;
        logic [CHW-1:0] ch;
        logic           cl;
        logic           out;
        logic [NCH-1:0] vld;
        logic           err;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic c, s, u, d, b, input logic [CHW-1:0] ch, input logic cl);
        @(negedge tck);
        cap = c; sh = s; upd = u; din = d; byp = b; ch_sel = ch; clr = cl;
        @(posedge tck);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] exp_w;
        cap_data = {32'h8000_0000, 32'hA5A5_0F0F, 32'h0000_0001, 32'h1234_5678};
        //            c  s  u  d  b  ch cl  out vld  err
        tbl[0]  = '{1, 0, 0, 0, 1, 0, 0,  0, 4'h0, 0};
        tbl[1]  = '{0, 1, 0, 1, 0, 0, 0,  1, 4'h0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 0,  0, 4'h0, 0};
        tbl[3]  = '{0, 1, 0, 1, 0, 0, 0,  1, 4'h0, 0};
        tbl[4]  = '{0, 0, 1, 0, 0, 0, 0,  1, 4'h0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 3, 0,  1, 4'h0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 0,  0, 4'h0, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 0, 0,  0, 4'h0, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1,  0, 4'h0, 0};
        tbl[9]  = '{1, 0, 0, 0, 0, 1, 0,  0, 4'h0, 0};
        tbl[10] = '{1, 1, 1, 0, 0, 3, 0,  1, 4'h0, 0};
        tbl[11] = '{0, 0, 1, 0, 0, 0, 0,  1, 4'h0, 1};
        tbl[12] = '{1, 0, 0, 0, 0, 3, 0,  1, 4'h0, 1};
        tbl[13] = '{0, 0, 1, 0, 0, 0, 1,  1, 4'h0, 1};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 1,  1, 4'h0, 0};
        tbl[15] = '{0, 1, 0, 0, 0, 0, 0,  0, 4'h0, 0};
        tbl[16] = '{0, 0, 1, 0, 0, 0, 0,  0, 4'h0, 0};

        #12;
        chk("rst_out", dout, 0);
        chk("rst_upd_data", upd_data, 0);
        chk("rst_vld", upd_vld, 0);
        chk("rst_err", len_err, 0);
        @(negedge tck);
        arst_l = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].c, tbl[i].s, tbl[i].u, tbl[i].d, tbl[i].b, tbl[i].ch, tbl[i].cl);
            chk($sformatf("tbl%0d_out", i), dout, tbl[i].out);
            chk($sformatf("tbl%0d_vld", i), upd_vld, tbl[i].vld);
            chk($sformatf("tbl%0d_err", i), len_err, tbl[i].err);
            chk($sformatf("tbl%0d_upd_data", i), upd_data, 0);
        end

        // all three commands together: capture only, counter cleared
        step(1, 1, 1, 1, 0, 2, 0);
        chk("prio_cnt", dut.cnt, 0);
        chk("prio_vld", upd_vld, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // full 32-bit transfer on channel 2
        exp_w = 32'hA5A5_0F0F;
        step(1, 0, 0, 0, 0, 2, 0);
        for (int i = 31; i >= 0; i--) begin
            chk($sformatf("ser_bit%0d", i), dout, exp_w[i]);
            step(0, 1, 0, 1, 0, 0, 0);
        end
        step(0, 0, 1, 0, 0, 0, 0);
        chk("full_upd_data", upd_data, 32'hFFFF_FFFF);
        chk("full_vld", upd_vld, 4'b0100);
        chk("full_err", len_err, 0);
        idle();
        chk("full_vld_gone", upd_vld, 0);

        // short shift
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("short_err", len_err, 1);
        chk("short_vld", upd_vld, 0);
        chk("short_upd_data", upd_data, 32'hFFFF_FFFF);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("short_clr", len_err, 0);

        // over-shift saturates the counter
        step(1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0, 0, 0);
        chk("over_cnt", dut.cnt, 33);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("over_err", len_err, 1);
        chk("over_vld", upd_vld, 0);
        chk("over_upd_data", upd_data, 32'hFFFF_FFFF);
        step(0, 0, 0, 0, 0, 0, 1);

        // out-of-range channel: zeros captured, full-length update rejected
        step(1, 0, 0, 0, 0, 5, 0);
        chk("oor_out", dout, 0);
        for (int i = 0; i < 32; i++) step(0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("oor_err", len_err, 1);
        chk("oor_vld", upd_vld, 0);
        chk("oor_upd_data", upd_data, 32'hFFFF_FFFF);
        step(0, 0, 0, 0, 0, 0, 1);

        // reset mid-shift
        step(1, 0, 0, 0, 0, 2, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 1, 0, 0, 0);
        #2 arst_l = 1'b0;
        #1;
        chk("arst_out", dout, 0);
        chk("arst_upd_data", upd_data, 0);
        chk("arst_vld", upd_vld, 0);
        chk("arst_err", len_err, 0);
        chk("arst_cnt", dut.cnt, 0);
        @(negedge tck);
        @(negedge tck);
        sh = 1'b0;
        arst_l = 1'b1;
        step(0, 0, 1, 0, 0, 0, 0);
        chk("post_rst_vld", upd_vld, 0);
        chk("post_rst_err", len_err, 0);
        chk("post_rst_upd_data", upd_data, 0);
        idle();
        chk("post_rst_vld2", upd_vld, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/efc_tck_dr.md
EFC_TCK_DR -- requirements
Module: efc_tck_dr

Interface
REQ-001 SHALL have parameter WIDTH, default 32: shift data register length in bits; legal range 2 to 64.
REQ-002 SHALL have parameter NCH, default 4: number of capture/update channels; legal range 1 to 8.
REQ-003 SHALL have parameter CHW, default 2: channel select width; CHW >= ceil(log2(NCH)), minimum 1.
REQ-004 SHALL have parameter CNTW, default 6: shift counter width; CNTW >= ceil(log2(WIDTH+2)).
REQ-005 SHALL have port tck, input, 1: sole clock; all state updates on the rising edge.
REQ-006 SHALL have port arst_l, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port ctu_efc_capturedr, input, 1: capture selected channel into shift register.
REQ-008 SHALL have port ctu_efc_shiftdr, input, 1: shift one bit per cycle.
REQ-009 SHALL have port ctu_efc_updatedr, input, 1: commit shifted value to the latched channel.
REQ-010 SHALL have port ctu_efc_data_in, input, 1: serial in.
REQ-011 SHALL have port ctu_efc_bypass, input, 1: select 1-bit bypass path; sampled at capture.
REQ-012 SHALL have port ctu_efc_ch_sel, input, CHW: channel index; sampled at capture.
REQ-013 SHALL have port cap_data, input, NCH*WIDTH: channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-014 SHALL have port clr_err, input, 1: synchronous clear of len_err.
REQ-015 SHALL have port efc_ctu_data_out, output, 1: serial out.
REQ-016 SHALL have port upd_data, output, WIDTH: last committed value.
REQ-017 SHALL have port upd_vld, output, NCH: one-hot, one-cycle commit strobe per channel.
REQ-018 SHALL have port len_err, output, 1: sticky shift-length error flag.

Function
REQ-019 SHALL implement FSM states IDLE, CAPT, SHIFT.
REQ-020 Command priority SHALL be capturedr > shiftdr > updatedr when asserted in the same cycle; lower-priority commands are ignored that cycle.
REQ-021 capturedr in any state SHALL: load sr <= cap_data slice for ch_sel; latch ch_sel and bypass into ch_q and byp_q; clear cnt to 0; clear bypass bit to 0; enter CAPT.
REQ-022 ch_sel >= NCH at capture SHALL load all zeros into sr; a subsequent valid-length update SHALL produce no upd_vld and SHALL set len_err.
REQ-023 shiftdr in CAPT or SHIFT with byp_q=0 SHALL perform sr <= {sr[WIDTH-2:0], ctu_efc_data_in}, increment cnt saturating at WIDTH+1, and enter or remain in SHIFT.
REQ-024 shiftdr with byp_q=1 SHALL load the bypass bit from ctu_efc_data_in and leave sr and cnt unchanged.
REQ-025 shiftdr in IDLE SHALL shift sr, leave cnt unchanged and remain in IDLE, matching legacy free-shift behaviour.
REQ-026 updatedr in CAPT or SHIFT SHALL return the FSM to IDLE.
REQ-027 updatedr with byp_q=0, cnt==WIDTH and ch_q<NCH SHALL: load upd_data <= sr in the same edge; pulse upd_vld[ch_q] high for exactly the next cycle.
REQ-028 updatedr with byp_q=0 and cnt!=WIDTH (short, zero or over-shift) SHALL set len_err, leave upd_data unchanged and produce no pulse.
REQ-029 updatedr with byp_q=1, or updatedr in IDLE, SHALL have no effect on upd_data, upd_vld or len_err.
REQ-030 efc_ctu_data_out SHALL be the bypass bit when byp_q=1, else sr[WIDTH-1]; combinational from registers only.
REQ-031 len_err SHALL remain set until clr_err; a set and a clear in the same cycle SHALL resolve to set.
REQ-032 Capture-to-first-serial-bit latency SHALL be one tck edge; the shift datapath SHALL add no pipeline stages.

Reset
REQ-033 arst_l low SHALL asynchronously force: FSM=IDLE; sr, upd_data, cnt, ch_q and the bypass bit to 0; byp_q=0; upd_vld=0; len_err=0; efc_ctu_data_out=0.
REQ-034 Reset asserted mid-shift SHALL abandon the transfer; no upd_vld pulse SHALL be generated on reset release.

Verification
REQ-035 WIDTH=32, NCH=4: capture with ch_sel=2 and cap_data ch2=0xA5A5_0F0F, then 32 shifts of din=1 -> data_out sequence equals 0xA5A50F0F MSB-first; update -> upd_data=0xFFFF_FFFF and upd_vld=4'b0100 for one cycle.
REQ-036 Capture, 31 shifts, update -> len_err=1, upd_vld=0, upd_data unchanged; clr_err -> len_err=0.
REQ-037 Capture, 40 shifts, update -> cnt saturates at 33, len_err=1, no pulse.
REQ-038 bypass=1 at capture, shift 1,0,1 -> data_out equals 0 then 1 then 0 one cycle delayed; update -> no pulse, no len_err.
REQ-039 capturedr+shiftdr+updatedr asserted together -> capture only: cnt=0, state CAPT, no pulse.
REQ-040 arst_l pulsed low after 16 shifts -> all outputs 0 immediately; update after release -> no effect.
